// File: rtl/lcd_nibble_writer_if.sv
// Request/status handshake between the LCD sequencer and the nibble writer.
interface lcd_nibble_writer_if;
    logic       start;
    logic [7:0] data;
    logic       rs;
    logic       nib_only;
    logic       busy;
    logic       done;

    modport master (
        output start, data, rs, nib_only,
        input  busy, done
    );

    modport slave (
        input  start, data, rs, nib_only,
        output busy, done
    );
endinterface

// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit bus writer: high/low nibble with timed E strobes, then exec wait.
// Optional LCD_LONG_CMD_EN: clear/home commands use LONG_EXEC_CYC for the exec wait.
module lcd_nibble_writer #(
    parameter int SETUP_CYC     = 4,
    parameter int E_HIGH_CYC    = 12,
    parameter int GAP_CYC       = 50,
    parameter int EXEC_CYC      = 2500,
    parameter int LONG_EXEC_CYC = 100000
) (
    input  logic                CLK,
    input  logic                RST_N,
    lcd_nibble_writer_if.slave  req,
    output logic [4:0]          LCD_D,
    output logic                LCD_E
);

    localparam int M1   = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
    localparam int M2   = (M1 > GAP_CYC) ? M1 : GAP_CYC;
    localparam int M3   = (M2 > EXEC_CYC) ? M2 : EXEC_CYC;
    localparam int MAXP = (M3 > LONG_EXEC_CYC) ? M3 : LONG_EXEC_CYC;
    localparam int CW   = $clog2(MAXP) + 1;

    typedef enum logic [2:0] {
        IDLE, SETUP_H, EH_H, GAP, SETUP_L, EH_L, EXEC, DONE
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [4:0]      d_n;
    logic [3:0]      lo_q;
    logic            rs_q, nib_q;
    logic            busy_q, done_q;
    logic            acc;
    logic [CW-1:0]   exec_ld;

`ifdef LCD_LONG_CMD_EN
    logic long_q, long_n;

    assign long_n = !req.rs && !req.nib_only &&
                    (req.data == 8'h01 || req.data == 8'h02);
    assign exec_ld = long_q ? CW'(LONG_EXEC_CYC - 1) : CW'(EXEC_CYC - 1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            long_q <= 1'b0;
        else if (acc)
            long_q <= long_n;
    end
`else
    assign exec_ld = CW'(EXEC_CYC - 1);
`endif

    always_comb begin
        state_n = state;
        cnt_n   = (cnt == '0) ? '0 : cnt - 1'b1;
        d_n     = LCD_D;
        acc     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req.start) begin
                    acc     = 1'b1;
                    state_n = SETUP_H;
                    cnt_n   = CW'(SETUP_CYC - 1);
                    d_n     = {req.rs, req.data[7:4]};
                end
            end
            SETUP_H: if (cnt == '0) begin
                state_n = EH_H;
                cnt_n   = CW'(E_HIGH_CYC - 1);
            end
            EH_H: if (cnt == '0) begin
                if (nib_q) begin
                    state_n = EXEC;
                    cnt_n   = exec_ld;
                end else begin
                    state_n = GAP;
                    cnt_n   = CW'(GAP_CYC - 1);
                end
            end
            GAP: if (cnt == '0) begin
                state_n = SETUP_L;
                cnt_n   = CW'(SETUP_CYC - 1);
                d_n     = {rs_q, lo_q};
            end
            SETUP_L: if (cnt == '0) begin
                state_n = EH_L;
                cnt_n   = CW'(E_HIGH_CYC - 1);
            end
            EH_L: if (cnt == '0) begin
                state_n = EXEC;
                cnt_n   = exec_ld;
            end
            EXEC: if (cnt == '0) begin
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Pin outputs are registered from the next state so E never glitches.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            cnt    <= '0;
            LCD_D  <= 5'b0;
            LCD_E  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            lo_q   <= 4'b0;
            rs_q   <= 1'b0;
            nib_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            LCD_D  <= d_n;
            LCD_E  <= (state_n == EH_H) || (state_n == EH_L);
            busy_q <= (state_n != IDLE) && (state_n != DONE);
            done_q <= (state_n == DONE);
            if (acc) begin
                lo_q  <= req.data[3:0];
                rs_q  <= req.rs;
                nib_q <= req.nib_only;
            end
        end
    end

    assign req.busy = busy_q;
    assign req.done = done_q;

endmodule
